// File: rtl/eth_udp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : eth_udp_pkg
// Description : Shared AXI response codes, register-slave FSM state encodings
//               and the byte-lane merge helper for the eth/arp/udp stack.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_udp_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE    = 2'd0;
    localparam logic [1:0] W_HAVE_AW = 2'd1;
    localparam logic [1:0] W_HAVE_W  = 2'd2;
    localparam logic [1:0] W_RESP    = 2'd3;

    localparam logic [0:0] R_IDLE  = 1'b0;
    localparam logic [0:0] R_VALID = 1'b1;

    // Byte i of the result comes from new_val when strb[i] is set, else old_val.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_udp_axil_slave_regs_if.sv
`default_nettype none
// ============================================================================
// Interface   : eth_udp_axil_slave_regs_if
// Description : AXI4-Lite bus bundle (five channels) for the stack register slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface eth_udp_axil_slave_regs_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/eth_udp_axil_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : eth_udp_axil_slave_regs
// Description : AXI4-Lite responder for the stack control registers; exposes
//               register contents and per-register commit pulses to the core.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_udp_axil_slave_regs
    import eth_udp_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 6,
    parameter int          NUM_REGS           = 4,
    parameter logic [31:0] RESET_VAL          = 32'h0
) (
    input  wire logic                                ACLK,
    input  wire logic                                ARESET,
    eth_udp_axil_slave_regs_if.slave                 s_axi,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]                      reg_wr_pulse
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    logic [1:0]             r_wstate, w_wstate_nxt;
    logic [0:0]             r_rstate;
    logic                   r_awready, r_wready, r_bvalid;
    logic [1:0]             r_bresp;
    logic                   r_arready, r_rvalid;
    logic [1:0]             r_rresp;
    logic [DW-1:0]          r_rdata;
    logic [IDX_W-1:0]       r_widx;
    logic [DW-1:0]          r_wdata;
    logic [3:0]             r_wstrb;
    logic [DW*NUM_REGS-1:0] r_regs;
    logic [NUM_REGS-1:0]    r_pulse;

    logic                   w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [IDX_W-1:0]       w_widx, w_ridx;
    logic [DW-1:0]          w_wdata, w_rval;
    logic [3:0]             w_wstrb;
    logic                   w_whit, w_rhit;
    logic                   w_unused;

    assign w_aw_hs = s_axi.awvalid & r_awready;
    assign w_w_hs  = s_axi.wvalid  & r_wready;
    assign w_ar_hs = s_axi.arvalid & r_arready;

    // A handshake in the commit cycle bypasses the holding registers.
    assign w_widx  = w_aw_hs ? s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2] : r_widx;
    assign w_wdata = w_w_hs  ? s_axi.wdata : r_wdata;
    assign w_wstrb = w_w_hs  ? s_axi.wstrb : r_wstrb;
    assign w_ridx  = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];

    assign w_unused = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_commit     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wstate_nxt = W_RESP;
                    w_commit     = 1'b1;
                end else if (w_aw_hs) begin
                    w_wstate_nxt = W_HAVE_AW;
                end else if (w_w_hs) begin
                    w_wstate_nxt = W_HAVE_W;
                end
            end
            W_HAVE_AW: if (w_w_hs) begin
                w_wstate_nxt = W_RESP;
                w_commit     = 1'b1;
            end
            W_HAVE_W: if (w_aw_hs) begin
                w_wstate_nxt = W_RESP;
                w_commit     = 1'b1;
            end
            W_RESP: if (s_axi.bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_whit = 1'b0;
        w_rhit = 1'b0;
        w_rval = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_widx == IDX_W'(k)) w_whit = 1'b1;
            if (w_ridx == IDX_W'(k)) begin
                w_rhit = 1'b1;
                w_rval = r_regs[DW*k +: DW];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= AXI_RESP_OKAY;
            r_widx    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_regs    <= {NUM_REGS{RESET_VAL}};
            r_pulse   <= '0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_W);
            r_wready  <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_AW);
            if (w_aw_hs) r_widx <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            if (w_w_hs) begin
                r_wdata <= s_axi.wdata;
                r_wstrb <= s_axi.wstrb;
            end
            r_pulse <= '0;
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_whit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (w_widx == IDX_W'(k)) begin
                        r_regs[DW*k +: DW] <= byte_merge(r_regs[DW*k +: DW], w_wdata, w_wstrb);
                        r_pulse[k]         <= 1'b1;
                    end
                end
            end else if (r_bvalid && s_axi.bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Register values are sampled at the AR handshake edge, so a same-edge commit is not visible.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= AXI_RESP_OKAY;
            r_rdata   <= '0;
        end else if (r_rstate == R_IDLE) begin
            r_arready <= 1'b1;
            if (w_ar_hs) begin
                r_rstate  <= R_VALID;
                r_arready <= 1'b0;
                r_rvalid  <= 1'b1;
                r_rdata   <= w_rval;
                r_rresp   <= w_rhit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end
        end else if (s_axi.rready) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
        end
    end

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rresp   = r_rresp;
    assign s_axi.rdata   = r_rdata;
    assign reg_q         = r_regs;
    assign reg_wr_pulse  = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_eth_udp_axil_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_udp_axil_slave_regs
// Description : Directed self-checking bench for the AXI4-Lite register slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_udp_axil_slave_regs;
    import eth_udp_pkg::*;

    localparam int NR = 4;
    localparam int AW = 6;

    logic            ACLK   = 1'b0;
    logic            ARESET = 1'b0;
    logic [32*NR-1:0] reg_q;
    logic [NR-1:0]   reg_wr_pulse;

    int total = 0;
    int bad   = 0;

    eth_udp_axil_slave_regs_if #(.ADDR_W(AW), .DATA_W(32)) s_axi ();

    eth_udp_axil_slave_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NR),
        .RESET_VAL(32'h0)
    ) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .s_axi(s_axi),
        .reg_q(reg_q),
        .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    int            pulse_cnt [NR];
    logic [NR-1:0] prev_pulse  = '0;
    logic [NR-1:0] last_pulse  = '0;
    int            long_pulses = 0;

    always @(posedge ACLK) begin
        prev_pulse <= reg_wr_pulse;
        if (reg_wr_pulse != '0) last_pulse <= reg_wr_pulse;
        if ((reg_wr_pulse & prev_pulse) != '0) long_pulses <= long_pulses + 1;
        for (int k = 0; k < NR; k++)
            if (reg_wr_pulse[k]) pulse_cnt[k] <= pulse_cnt[k] + 1;
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             output logic [1:0] resp);
        int   cyc;
        logic aw_done, w_done, aw_fire, w_fire;
        s_axi.awaddr = addr;
        s_axi.wdata  = data;
        s_axi.wstrb  = strb;
        cyc = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            if (!aw_done && cyc >= aw_dly) s_axi.awvalid = 1'b1;
            if (!w_done && cyc >= w_dly)   s_axi.wvalid  = 1'b1;
            aw_fire = s_axi.awvalid && s_axi.awready;
            w_fire  = s_axi.wvalid && s_axi.wready;
            tick();
            cyc++;
            if (aw_fire) begin aw_done = 1; s_axi.awvalid = 1'b0; end
            if (w_fire)  begin w_done  = 1; s_axi.wvalid  = 1'b0; end
        end
        s_axi.awvalid = 1'b0;
        s_axi.wvalid  = 1'b0;
        total++;
        if (!(aw_done && w_done)) begin
            bad++;
            $display("FAIL write_handshake addr=%h got aw=%0b w=%0b want both", addr, aw_done, w_done);
        end
        s_axi.bready = 1'b1;
        cyc = 0;
        while (!s_axi.bvalid && cyc < 40) begin tick(); cyc++; end
        total++;
        if (!s_axi.bvalid) begin
            bad++;
            $display("FAIL write_bvalid_timeout addr=%h got bvalid=0 want 1", addr);
        end
        resp = s_axi.bresp;
        tick();
        s_axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int   cyc;
        logic fire;
        s_axi.araddr  = addr;
        s_axi.arvalid = 1'b1;
        cyc = 0; fire = 0;
        while (!fire && cyc < 40) begin
            fire = s_axi.arready;
            tick();
            cyc++;
        end
        s_axi.arvalid = 1'b0;
        s_axi.rready  = 1'b1;
        cyc = 0;
        while (!s_axi.rvalid && cyc < 40) begin tick(); cyc++; end
        total++;
        if (!fire || !s_axi.rvalid) begin
            bad++;
            $display("FAIL read_timeout addr=%h got ar=%0b rvalid=%0b want 1 1", addr, fire, s_axi.rvalid);
        end
        data = s_axi.rdata;
        resp = s_axi.rresp;
        tick();
        s_axi.rready = 1'b0;
    endtask

    task automatic test_reset();
        #1 ARESET = 1'b1;
        tick(); tick();
        total++;
        if ({s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.arready, s_axi.rvalid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_handshake got=%b want=00000",
                     {s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.arready, s_axi.rvalid});
        end
        total++;
        if ({s_axi.bresp, s_axi.rresp, s_axi.rdata} !== 36'h0) begin
            bad++;
            $display("FAIL reset_resp_data got bresp=%b rresp=%b rdata=%h want 0", s_axi.bresp, s_axi.rresp, s_axi.rdata);
        end
        total++;
        if (reg_q !== '0 || reg_wr_pulse !== '0) begin
            bad++;
            $display("FAIL reset_regs got reg_q=%h pulse=%b want 0", reg_q, reg_wr_pulse);
        end
        ARESET = 1'b0;
        tick(); tick();
        total++;
        if ({s_axi.awready, s_axi.wready, s_axi.arready} !== 3'b111) begin
            bad++;
            $display("FAIL ready_after_reset got=%b want=111", {s_axi.awready, s_axi.wready, s_axi.arready});
        end
    endtask

    task automatic test_basic_rw();
        logic [1:0]  resp;
        logic [31:0] data;
        for (int i = 0; i < NR; i++) begin
            axi_write(AW'(4*i), 32'(i+1), 4'hF, 0, 0, resp);
            total++;
            if (resp !== AXI_RESP_OKAY) begin
                bad++;
                $display("FAIL basic_bresp reg=%0d got=%b want=00", i, resp);
            end
        end
        for (int i = 0; i < NR; i++) begin
            axi_read(AW'(4*i), data, resp);
            total++;
            if (data !== 32'(i+1) || resp !== AXI_RESP_OKAY) begin
                bad++;
                $display("FAIL basic_read reg=%0d got data=%h resp=%b want data=%h resp=00", i, data, resp, i+1);
            end
        end
        total++;
        if (reg_q !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
            bad++;
            $display("FAIL basic_reg_q got=%h want=%h", reg_q, {32'd4, 32'd3, 32'd2, 32'd1});
        end
        tick();
        total++;
        if (pulse_cnt[0] != 1 || pulse_cnt[1] != 1 || pulse_cnt[2] != 1 || pulse_cnt[3] != 1) begin
            bad++;
            $display("FAIL basic_pulse_count got=%0d %0d %0d %0d want 1 1 1 1",
                     pulse_cnt[0], pulse_cnt[1], pulse_cnt[2], pulse_cnt[3]);
        end
    endtask

    task automatic test_strobe();
        logic [1:0]  resp;
        logic [31:0] data;
        int          c0, c1, c2, c3;
        c0 = pulse_cnt[0]; c1 = pulse_cnt[1]; c2 = pulse_cnt[2]; c3 = pulse_cnt[3];
        axi_write(6'h04, 32'hAABBCCDD, 4'b0011, 0, 0, resp);
        axi_read(6'h04, data, resp);
        total++;
        if (data !== 32'h0000CCDD || resp !== AXI_RESP_OKAY) begin
            bad++;
            $display("FAIL strobe_read got=%h resp=%b want=0000ccdd resp=00", data, resp);
        end
        tick();
        total++;
        if (last_pulse !== 4'b0010 || pulse_cnt[1] != c1 + 1 || pulse_cnt[0] != c0
            || pulse_cnt[2] != c2 || pulse_cnt[3] != c3 || long_pulses != 0) begin
            bad++;
            $display("FAIL strobe_pulse got last=%b cnt1_delta=%0d long=%0d want 0010 1 0",
                     last_pulse, pulse_cnt[1] - c1, long_pulses);
        end
        // Zero-strobe write leaves the value but still pulses.
        axi_write(6'h09, 32'hFFFFFFFF, 4'b0000, 0, 0, resp);
        tick();
        total++;
        if (reg_q[64 +: 32] !== 32'd3 || pulse_cnt[2] != c2 + 1 || resp !== AXI_RESP_OKAY) begin
            bad++;
            $display("FAIL zero_strobe got reg2=%h pulses=%0d resp=%b want 00000003 %0d 00",
                     reg_q[64 +: 32], pulse_cnt[2], resp, c2 + 1);
        end
    endtask

    task automatic test_skew();
        logic [1:0] resp;
        axi_write(6'h08, 32'h11112222, 4'hF, 3, 0, resp);
        total++;
        if (resp !== AXI_RESP_OKAY || s_axi.bvalid !== 1'b0 || reg_q[64 +: 32] !== 32'h11112222) begin
            bad++;
            $display("FAIL skew_w_first got resp=%b bvalid=%b reg2=%h want 00 0 11112222",
                     resp, s_axi.bvalid, reg_q[64 +: 32]);
        end
        axi_write(6'h0C, 32'h33334444, 4'hF, 0, 3, resp);
        total++;
        if (resp !== AXI_RESP_OKAY || s_axi.bvalid !== 1'b0 || reg_q[96 +: 32] !== 32'h33334444) begin
            bad++;
            $display("FAIL skew_aw_first got resp=%b bvalid=%b reg3=%h want 00 0 33334444",
                     resp, s_axi.bvalid, reg_q[96 +: 32]);
        end
    endtask

    task automatic test_backpressure();
        s_axi.awaddr = 6'h00; s_axi.wdata = 32'hCAFE0001; s_axi.wstrb = 4'hF;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.bready = 1'b0;
        tick();
        // Offer a second write while the response is stalled; it must not be taken.
        s_axi.awaddr = 6'h04; s_axi.wdata = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({s_axi.bvalid, s_axi.bresp, s_axi.awready, s_axi.wready} !== 5'b10000) begin
                bad++;
                $display("FAIL bready_stall cycle=%0d got=%b want=10000", i,
                         {s_axi.bvalid, s_axi.bresp, s_axi.awready, s_axi.wready});
            end
            tick();
        end
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b1;
        tick();
        s_axi.bready = 1'b0;
        total++;
        if (s_axi.bvalid !== 1'b0 || reg_q[31:0] !== 32'hCAFE0001 || reg_q[63:32] !== 32'h0000CCDD) begin
            bad++;
            $display("FAIL bready_release got bvalid=%b reg0=%h reg1=%h want 0 cafe0001 0000ccdd",
                     s_axi.bvalid, reg_q[31:0], reg_q[63:32]);
        end
        s_axi.araddr = 6'h00; s_axi.arvalid = 1'b1; s_axi.rready = 1'b0;
        tick();
        s_axi.araddr = 6'h04;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (s_axi.rvalid !== 1'b1 || s_axi.rdata !== 32'hCAFE0001 || s_axi.rresp !== 2'b00
                || s_axi.arready !== 1'b0) begin
                bad++;
                $display("FAIL rready_stall cycle=%0d got rvalid=%b rdata=%h rresp=%b arready=%b want 1 cafe0001 00 0",
                         i, s_axi.rvalid, s_axi.rdata, s_axi.rresp, s_axi.arready);
            end
            tick();
        end
        s_axi.arvalid = 1'b0; s_axi.rready = 1'b1;
        tick();
        s_axi.rready = 1'b0;
        total++;
        if (s_axi.rvalid !== 1'b0 || s_axi.arready !== 1'b1) begin
            bad++;
            $display("FAIL rready_release got rvalid=%b arready=%b want 0 1", s_axi.rvalid, s_axi.arready);
        end
    endtask

    task automatic test_read_during_write();
        s_axi.awaddr = 6'h0C; s_axi.wdata = 32'h00000099; s_axi.wstrb = 4'hF; s_axi.araddr = 6'h0C;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.arvalid = 1'b1;
        tick();
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; s_axi.arvalid = 1'b0;
        total++;
        if (s_axi.rvalid !== 1'b1 || s_axi.rdata !== 32'h33334444 || s_axi.bvalid !== 1'b1
            || reg_q[96 +: 32] !== 32'h00000099) begin
            bad++;
            $display("FAIL read_during_write got rvalid=%b rdata=%h bvalid=%b reg3=%h want 1 33334444 1 00000099",
                     s_axi.rvalid, s_axi.rdata, s_axi.bvalid, reg_q[96 +: 32]);
        end
        s_axi.bready = 1'b1; s_axi.rready = 1'b1;
        tick();
        s_axi.bready = 1'b0; s_axi.rready = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [1:0]       resp;
        logic [31:0]      data;
        logic [32*NR-1:0] snap;
        int               psum;
        snap = reg_q;
        psum = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
        axi_write(6'h10, 32'hDEADBEEF, 4'hF, 0, 0, resp);
        total++;
        if (resp !== AXI_RESP_SLVERR) begin
            bad++;
            $display("FAIL oor_bresp got=%b want=10", resp);
        end
        axi_read(6'h10, data, resp);
        total++;
        if (data !== 32'h0 || resp !== AXI_RESP_SLVERR) begin
            bad++;
            $display("FAIL oor_read got data=%h resp=%b want 0 10", data, resp);
        end
        axi_read(6'h3C, data, resp);
        total++;
        if (data !== 32'h0 || resp !== AXI_RESP_SLVERR) begin
            bad++;
            $display("FAIL oor_read_top got data=%h resp=%b want 0 10", data, resp);
        end
        tick();
        total++;
        if (reg_q !== snap || pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] != psum) begin
            bad++;
            $display("FAIL oor_side_effect got reg_q=%h want=%h", reg_q, snap);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0]  resp;
        logic [31:0] data;
        s_axi.awaddr = 6'h00; s_axi.awvalid = 1'b1;
        tick();
        s_axi.awvalid = 1'b0;
        #2 ARESET = 1'b1;
        #1;
        total++;
        if ({s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.arready, s_axi.rvalid} !== 5'b0
            || reg_q !== '0 || reg_wr_pulse !== '0) begin
            bad++;
            $display("FAIL reset_mid got hs=%b reg_q=%h want 0 0",
                     {s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.arready, s_axi.rvalid}, reg_q);
        end
        tick();
        ARESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (s_axi.bvalid !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_no_resp cycle=%0d got bvalid=%b want 0", i, s_axi.bvalid);
            end
        end
        for (int i = 0; i < NR; i++) begin
            axi_read(AW'(4*i), data, resp);
            total++;
            if (data !== 32'h0 || resp !== AXI_RESP_OKAY) begin
                bad++;
                $display("FAIL reset_mid_read reg=%0d got data=%h resp=%b want 0 00", i, data, resp);
            end
        end
    endtask

    initial begin
        s_axi.awaddr = '0; s_axi.awprot = 3'b0; s_axi.awvalid = 1'b0;
        s_axi.wdata  = '0; s_axi.wstrb  = '0;   s_axi.wvalid  = 1'b0; s_axi.bready = 1'b0;
        s_axi.araddr = '0; s_axi.arprot = 3'b0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
        test_reset();
        test_basic_rw();
        test_strobe();
        test_skew();
        test_backpressure();
        test_read_during_write();
        test_out_of_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
